programmable_sequence_generator_fsm: RTL and testbench

- Serial pattern source that drives the `w` input of the programmable sequence detector.
- A stored length `n` and polarity define a framed burst: one opposite-polarity lead bit, then `n` bits of the pattern polarity, then one opposite-polarity tail bit.
- The burst is emitted one bit per clock, once or repeatedly.
- `n_out`, `count` and `state` are exposed for display on HEX digits.

---
 rtl/programmable_sequence_generator_fsm.sv | 117 +++++++++++
 tb/tb_programmable_sequence_generator_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/programmable_sequence_generator_fsm.sv
// Framed-burst serial pattern source: one lead bit of the opposite polarity, n pattern bits,
// then one tail bit of the opposite polarity. Bursts run once or back-to-back.
module programmable_sequence_generator_fsm #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             resetnot,
  input  logic [WIDTH-1:0] n_in,
  input  logic             pol_in,
  input  logic             save,
  input  logic             start,
  input  logic             repeat_en,
  output logic             w,
  output logic [WIDTH-1:0] n_out,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    RUN  = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             pol_q, pol_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      state_q <= IDLE;
      n_q     <= '0;
      pol_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      pol_q   <= pol_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    pol_d   = pol_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        // A save in the same cycle as start takes priority and drops the start.
        if (save) begin
          n_d     = n_in;
          pol_d   = pol_in;
          count_d = '0;
          state_d = IDLE;
        end else if (start) begin
          count_d = '0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (n_q != '0) begin
          count_d = WIDTH'(1);
          state_d = RUN;
        end else begin
          state_d = TAIL;
        end
      end
      RUN: begin
        // Compare before incrementing so the all-ones length never wraps.
        if (count_q == n_q) begin
          state_d = TAIL;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      TAIL: begin
        if (repeat_en) begin
          count_d = '0;
          state_d = LEAD;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w    = IDLE_LEVEL;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      LEAD, TAIL: begin
        w    = ~pol_q;
        busy = 1'b1;
      end
      RUN: begin
        w    = pol_q;
        busy = 1'b1;
      end
      DONE:    done = 1'b1;
      default: w = IDLE_LEVEL;
    endcase
  end

  assign n_out = n_q;
  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_programmable_sequence_generator_fsm.sv
// Directed bench for the framed-burst generator; expected per-cycle outputs are queued
// when a burst is requested and checked as each cycle completes.
module tb_programmable_sequence_generator_fsm;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             resetnot;
  logic [WIDTH-1:0] n_in;
  logic             pol_in;
  logic             save;
  logic             start;
  logic             repeat_en;
  logic             w;
  logic [WIDTH-1:0] n_out;
  logic [WIDTH-1:0] count;
  logic [2:0]       state;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             w;
    logic [WIDTH-1:0] cnt;
    logic [2:0]       st;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] n;
  } exp_t;

  exp_t exp_q[$];

  programmable_sequence_generator_fsm #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0)) dut (
    .clock    (clock),
    .resetnot (resetnot),
    .n_in     (n_in),
    .pol_in   (pol_in),
    .save     (save),
    .start    (start),
    .repeat_en(repeat_en),
    .w        (w),
    .n_out    (n_out),
    .count    (count),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic wv, input int c, input int st, input logic b,
                      input logic d, input int n);
    exp_t e;
    e.w = wv; e.cnt = WIDTH'(c); e.st = 3'(st); e.busy = b; e.done = d; e.n = WIDTH'(n);
    exp_q.push_back(e);
  endtask

  // Expected cycles for one burst from LEAD through TAIL, state codes written literally.
  task automatic push_burst(input int n, input logic pol);
    push(~pol, 0, 1, 1'b1, 1'b0, n);
    for (int i = 1; i <= n; i++) push(pol, i, 2, 1'b1, 1'b0, n);
    push(~pol, n, 3, 1'b1, 1'b0, n);
  endtask

  task automatic push_done(input int c, input int n);
    push(1'b0, c, 4, 1'b0, 1'b1, n);
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".state"}, 32'(state), 32'(e.st));
    chk({tag, ".w"},     32'(w),     32'(e.w));
    chk({tag, ".count"}, 32'(count), 32'(e.cnt));
    chk({tag, ".busy"},  32'(busy),  32'(e.busy));
    chk({tag, ".done"},  32'(done),  32'(e.done));
    chk({tag, ".n_out"}, 32'(n_out), 32'(e.n));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_save(input int n, input logic pol, input string tag);
    n_in = WIDTH'(n); pol_in = pol; save = 1'b1;
    step();
    save = 1'b0;
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".n_out"}, 32'(n_out), 32'(n));
    chk({tag, ".busy"},  32'(busy),  32'd0);
  endtask

  task automatic kick(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_front(tag);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      step();
      check_front(tag);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".w"},     32'(w),     32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".n_out"}, 32'(n_out), 32'd0);
    chk({tag, ".busy"},  32'(busy),  32'd0);
    chk({tag, ".done"},  32'(done),  32'd0);
  endtask

  initial begin
    resetnot = 1'b0; n_in = '0; pol_in = 1'b0; save = 1'b0; start = 1'b0; repeat_en = 1'b0;
    #12;
    check_reset("por");
    resetnot = 1'b1;
    step();
    check_reset("idle");

    // n=3, pol=1, single burst
    do_save(3, 1'b1, "save3");
    push_burst(3, 1'b1);
    push_done(3, 3);
    kick("n3");
    drain("n3");

    // n=0: LEAD straight to TAIL
    do_save(0, 1'b0, "save0");
    push_burst(0, 1'b0);
    push_done(0, 0);
    kick("n0");
    drain("n0");

    // n=15: count reaches all-ones without wrapping
    do_save(15, 1'b1, "save15");
    push_burst(15, 1'b1);
    push_done(15, 15);
    kick("n15");
    drain("n15");

    // repeating n=2 bursts, repeat dropped mid-RUN of the fourth burst
    do_save(2, 1'b1, "save2");
    repeat_en = 1'b1;
    for (int b = 0; b < 3; b++) push_burst(2, 1'b1);
    push(1'b0, 0, 1, 1'b1, 1'b0, 2);
    push(1'b1, 1, 2, 1'b1, 1'b0, 2);
    kick("rep");
    drain("rep");
    repeat_en = 1'b0;
    push(1'b1, 2, 2, 1'b1, 1'b0, 2);
    push(1'b0, 2, 3, 1'b1, 1'b0, 2);
    push_done(2, 2);
    drain("rep_end");

    // save and start together: save wins
    n_in = WIDTH'(5); pol_in = 1'b1; save = 1'b1; start = 1'b1;
    step();
    save = 1'b0; start = 1'b0;
    chk("both.state", 32'(state), 32'd0);
    chk("both.n_out", 32'(n_out), 32'd5);
    chk("both.busy",  32'(busy),  32'd0);

    // save during RUN is ignored
    push(1'b0, 0, 1, 1'b1, 1'b0, 5);
    push(1'b1, 1, 2, 1'b1, 1'b0, 5);
    push(1'b1, 2, 2, 1'b1, 1'b0, 5);
    kick("busy_save");
    drain("busy_save");
    n_in = WIDTH'(9); pol_in = 1'b0; save = 1'b1;
    push(1'b1, 3, 2, 1'b1, 1'b0, 5);
    drain("busy_save");
    save = 1'b0;
    push(1'b1, 4, 2, 1'b1, 1'b0, 5);
    push(1'b1, 5, 2, 1'b1, 1'b0, 5);
    push(1'b0, 5, 3, 1'b1, 1'b0, 5);
    push_done(5, 5);
    drain("busy_save_end");

    // asynchronous reset mid-RUN
    push(1'b0, 0, 1, 1'b1, 1'b0, 5);
    push(1'b1, 1, 2, 1'b1, 1'b0, 5);
    push(1'b1, 2, 2, 1'b1, 1'b0, 5);
    kick("pre_rst");
    drain("pre_rst");
    #2;
    resetnot = 1'b0;
    #1;
    check_reset("mid_rst");
    #1;
    resetnot = 1'b1;
    step();
    check_reset("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
